// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - shared state type and default widths for the PSRAM datapath
package psram_pkg;

  localparam int PSRAM_AW = 16;
  localparam int PSRAM_DW = 32;
  localparam int PSRAM_CW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/psram_tx_fifo.sv
// rtl/psram_tx_fifo.sv - show-ahead FIFO holding prefetched write words
module psram_tx_fifo
  import psram_pkg::*;
#(
  parameter int DW = PSRAM_DW,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CNTW = PW + 1
) (
  input  logic            hclk,
  input  logic            hrst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [DW-1:0]   din,
  output logic [DW-1:0]   dout,
  output logic [CNTW-1:0] count,
  output logic            empty,
  output logic            full
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNTW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero when empty so the stream data is clean out of reset.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge hclk) begin
    if (hrst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CNTW'(1);
      else if (do_pop && !do_push) count <= count - CNTW'(1);
    end
  end

  always_ff @(posedge hclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/psram_tx_buf.sv
// rtl/psram_tx_buf.sv - prefetches RAM words into a FIFO and streams them to the PSRAM TX engine
module psram_tx_buf
  import psram_pkg::*;
#(
  parameter int AW = PSRAM_AW,
  parameter int DW = PSRAM_DW,
  parameter int CW = PSRAM_CW,
  parameter int DEPTH = 4
) (
  input  logic          hclk,
  input  logic          hrst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [CW-1:0] word_cnt,
  output logic          ram_rd_req,
  output logic [AW-1:0] ram_rd_addr,
  input  logic          ram_rd_ack,
  input  logic [DW-1:0] ram_rdata,
  output logic          tx_vld,
  input  logic          tx_rdy,
  output logic [DW-1:0] tx_data,
  output logic          busy,
  output logic          done
);

  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   fetch_left;
  logic [CW-1:0]   fetch_left_nxt;
  logic [CW-1:0]   send_left;
  logic [CW-1:0]   send_left_nxt;
  logic [AW-1:0]   addr_nxt;
  logic            req_nxt;
  logic            done_nxt;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            fifo_full;
  logic [CNTW-1:0] fifo_count;
  logic [CNTW-1:0] count_nxt;

  // A start flushes the FIFO, so an ack or pop landing in that cycle is dropped.
  assign push   = ram_rd_req && ram_rd_ack && !start && !fifo_full;
  assign pop    = tx_vld && tx_rdy && !start;
  assign tx_vld = !fifo_empty;
  assign busy   = (state != IDLE);

  psram_tx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .hclk  (hclk),
    .hrst  (hrst),
    .push  (push),
    .pop   (pop),
    .flush (start),
    .din   (ram_rdata),
    .dout  (tx_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state       <= IDLE;
      fetch_left  <= '0;
      send_left   <= '0;
      ram_rd_addr <= '0;
      ram_rd_req  <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_left  <= fetch_left_nxt;
      send_left   <= send_left_nxt;
      ram_rd_addr <= addr_nxt;
      ram_rd_req  <= req_nxt;
      done        <= done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    fetch_left_nxt = fetch_left;
    send_left_nxt  = send_left;
    addr_nxt       = ram_rd_addr;
    done_nxt       = 1'b0;
    count_nxt      = fifo_count + CNTW'(push) - CNTW'(pop);

    if (start) begin
      fetch_left_nxt = word_cnt;
      send_left_nxt  = word_cnt;
      addr_nxt       = start_addr;
      count_nxt      = '0;
      if (word_cnt == '0) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = FETCH;
      end
    end else begin
      if (push) begin
        fetch_left_nxt = fetch_left - CW'(1);
        addr_nxt       = ram_rd_addr + AW'(1);
      end
      if (pop) send_left_nxt = send_left - CW'(1);

      case (state)
        FETCH: if (fetch_left_nxt == '0) state_nxt = DRAIN;
        DRAIN: begin
          if (send_left_nxt == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // An abort withdraws the request for one cycle before the new transfer fetches.
    req_nxt = (state_nxt == FETCH) && (fetch_left_nxt != '0) &&
              (count_nxt < DEPTH_C) && !(start && busy);
  end

endmodule

// File: tb/tb_psram_tx_buf.sv
// tb/tb_psram_tx_buf.sv - scoreboard bench for psram_tx_buf with a randomized RAM responder
`timescale 1ns/1ps
module tb_psram_tx_buf;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int DEPTH = 4;

  logic          hclk = 1'b0;
  logic          hrst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] word_cnt;
  logic          ram_rd_req;
  logic [AW-1:0] ram_rd_addr;
  logic          ram_rd_ack;
  logic [DW-1:0] ram_rdata;
  logic          tx_vld;
  logic          tx_rdy;
  logic [DW-1:0] tx_data;
  logic          busy;
  logic          done;

  psram_tx_buf #(.AW(AW), .DW(DW), .CW(CW), .DEPTH(DEPTH)) dut (
    .hclk        (hclk),
    .hrst        (hrst),
    .start       (start),
    .start_addr  (start_addr),
    .word_cnt    (word_cnt),
    .ram_rd_req  (ram_rd_req),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_ack  (ram_rd_ack),
    .ram_rdata   (ram_rdata),
    .tx_vld      (tx_vld),
    .tx_rdy      (tx_rdy),
    .tx_data     (tx_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int ack_maxd = 0;
  int rdy_mode = 1;
  bit spurious_en = 1'b0;
  logic [31:0] epoch = 32'd0;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  // RAM contents: a per-transfer pattern so stale words from an aborted transfer cannot match.
  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a, input logic [31:0] e);
    return ({a, ~a} ^ (e * 32'h9E3779B1)) + 32'h0000_1234;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // RAM responder: acks the live request after a random wait, sometimes acks with no request.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    ram_rd_ack = 1'b0;
    ram_rdata = '0;
    forever begin
      @(posedge hclk); #1;
      ram_rd_ack = 1'b0;
      ram_rdata = '0;
      if (ram_rd_req) begin
        if (wait_cnt == 0) begin
          ram_rd_ack = 1'b1;
          ram_rdata = ram_word(ram_rd_addr, epoch);
          wait_cnt = (ack_maxd == 0) ? 0 : int'($urandom_range(ack_maxd, 0));
        end else begin
          wait_cnt--;
        end
      end else if (spurious_en && ($urandom_range(3, 0) == 0)) begin
        ram_rd_ack = 1'b1;
        ram_rdata = $urandom;
      end
    end
  end

  initial begin
    tx_rdy = 1'b0;
    forever begin
      @(posedge hclk); #1;
      case (rdy_mode)
        0: tx_rdy = 1'b0;
        1: tx_rdy = 1'b1;
        default: tx_rdy = ($urandom_range(1, 0) == 1);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted request and every stream handshake.
  logic          prev_gap = 1'b1;
  logic          prev_req = 1'b0;
  logic          prev_ack = 1'b0;
  logic          prev_vld = 1'b0;
  logic          prev_rdy = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge hclk) begin
    if (!hrst && !start) begin
      if (ram_rd_req && ram_rd_ack) begin
        ack_cnt++;
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_addr: got request 0x%0h expected none", ram_rd_addr);
        end else begin
          chk("rd_addr", ram_rd_addr, exp_addr_q.pop_front());
        end
      end
      if (tx_vld && tx_rdy) begin
        pop_cnt++;
        if (exp_data_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_data: got word 0x%0h expected none", tx_data);
        end else begin
          chk("tx_data", tx_data, exp_data_q.pop_front());
        end
      end
      if (!prev_gap && prev_req && !prev_ack) begin
        chk("req_hold", ram_rd_req, 1);
        chk("addr_hold", ram_rd_addr, prev_addr);
      end
      if (!prev_gap && prev_vld && !prev_rdy) begin
        chk("vld_hold", tx_vld, 1);
        chk("data_hold", tx_data, prev_data);
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_after_last_word", exp_data_q.size(), 0);
    end
    prev_gap  = hrst || start;
    prev_req  = ram_rd_req;
    prev_ack  = ram_rd_ack;
    prev_vld  = tx_vld;
    prev_rdy  = tx_rdy;
    prev_addr = ram_rd_addr;
    prev_data = tx_data;
  end

  task automatic do_start(input logic [AW-1:0] a, input logic [CW-1:0] n);
    @(posedge hclk); #1;
    epoch++;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      exp_addr_q.push_back(a + AW'(i));
      exp_data_q.push_back(ram_word(a + AW'(i), epoch));
    end
    start = 1'b1;
    start_addr = a;
    word_cnt = n;
    @(posedge hclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge hclk);
      if (!busy && exp_data_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_complete"}, ok, 1);
    repeat (3) @(negedge hclk);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_req"}, ram_rd_req, 0);
    chk({nm, "_addr"}, ram_rd_addr, 0);
    chk({nm, "_vld"}, tx_vld, 0);
    chk({nm, "_data"}, tx_data, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0, p0, a1, p1, words, xfers;
    bit seen;
    logic [AW-1:0] ra;
    logic [CW-1:0] rn;

    hrst = 1'b1; start = 1'b0; start_addr = '0; word_cnt = '0;
    repeat (3) @(posedge hclk); #1;
    hrst = 1'b0;
    @(negedge hclk);
    check_reset("reset");

    // Basic transfer with same-cycle acks
    ack_maxd = 0; rdy_mode = 1; spurious_en = 1'b0;
    d0 = done_cnt; a0 = ack_cnt;
    do_start(16'h0010, 16'd3);
    @(negedge hclk);
    chk("basic_first_req", ram_rd_req, 1);
    chk("basic_first_addr", ram_rd_addr, 16'h0010);
    @(negedge hclk);
    chk("basic_vld_latency", tx_vld, 1);
    wait_idle("basic", 100);
    chk("basic_done_count", done_cnt - d0, 1);
    chk("basic_ack_count", ack_cnt - a0, 3);
    chk("basic_busy_low", busy, 0);

    // Backpressure: FIFO fills to DEPTH and requests stop
    rdy_mode = 0;
    @(negedge hclk);
    d0 = done_cnt; a0 = ack_cnt; p0 = pop_cnt;
    do_start(16'h0400, 16'd8);
    repeat (20) @(negedge hclk);
    chk("bp_acks_at_full", ack_cnt - a0, DEPTH);
    chk("bp_req_withheld", ram_rd_req, 0);
    chk("bp_head_vld", tx_vld, 1);
    chk("bp_head_data", tx_data, ram_word(16'h0400, epoch));
    rdy_mode = 1;
    wait_idle("bp", 200);
    chk("bp_ack_total", ack_cnt - a0, 8);
    chk("bp_pop_total", pop_cnt - p0, 8);
    chk("bp_done_count", done_cnt - d0, 1);

    // Zero-length transfer
    d0 = done_cnt;
    do_start(16'h0055, 16'd0);
    @(negedge hclk);
    chk("zero_done_cycle1", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_no_req", ram_rd_req, 0);
    repeat (4) begin
      @(negedge hclk);
      chk("zero_no_req_later", ram_rd_req, 0);
    end
    chk("zero_done_count", done_cnt - d0, 1);

    // Abort mid-transfer
    d0 = done_cnt; p0 = pop_cnt;
    do_start(16'h0100, 16'd6);
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge hclk);
      if (pop_cnt - p0 >= 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_two_pops", seen, 1);
    do_start(16'h0200, 16'd2);
    a1 = ack_cnt; p1 = pop_cnt;
    @(negedge hclk);
    chk("abort_req_drop", ram_rd_req, 0);
    chk("abort_fifo_flushed", tx_vld, 0);
    wait_idle("abort", 100);
    chk("abort_ack_count", ack_cnt - a1, 2);
    chk("abort_pop_count", pop_cnt - p1, 2);
    chk("abort_single_done", done_cnt - d0, 1);

    // Address wrap
    d0 = done_cnt; a0 = ack_cnt;
    do_start(16'hFFFF, 16'd2);
    wait_idle("wrap", 100);
    chk("wrap_ack_count", ack_cnt - a0, 2);
    chk("wrap_done_count", done_cnt - d0, 1);

    // Random stalls and spurious acks over ~1000 words
    ack_maxd = 3; rdy_mode = 2; spurious_en = 1'b1;
    d0 = done_cnt; p0 = pop_cnt; words = 0; xfers = 0;
    while (words < 1000) begin
      ra = AW'($urandom);
      rn = CW'($urandom_range(40, 0));
      do_start(ra, rn);
      wait_idle("rand", int'(rn) * 20 + 50);
      words += int'(rn);
      xfers++;
    end
    chk("rand_pop_total", pop_cnt - p0, words);
    chk("rand_done_count", done_cnt - d0, xfers);

    // Reset mid-transfer
    do_start(16'h3000, 16'd20);
    repeat (12) @(negedge hclk);
    d0 = done_cnt;
    @(posedge hclk); #1;
    hrst = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge hclk); #1;
    hrst = 1'b0;
    @(negedge hclk);
    check_reset("midreset");
    repeat (5) @(negedge hclk);
    chk("midreset_no_done", done_cnt - d0, 0);
    chk("midreset_no_req", ram_rd_req, 0);

    d0 = done_cnt; p0 = pop_cnt;
    do_start(16'h3100, 16'd5);
    wait_idle("recover", 200);
    chk("recover_pops", pop_cnt - p0, 5);
    chk("recover_done", done_cnt - d0, 1);

    spurious_en = 1'b0;
    repeat (2) @(negedge hclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psram_tx_buf.md
Name: psram_tx_buf

Overview:
Single-clock prefetch buffer for the PSRAM write path, the transmit counterpart of the receive buffer. On a start pulse it fetches a programmed number of 32-bit words from the on-chip RAM over a req/ack read port and queues them in a small FIFO. It presents them to the PSRAM transmit engine over a vld/rdy stream and pulses done when the last word has been accepted. Sits in the hclk domain between the RAM arbiter and the PSRAM TX datapath.

Parameters:
AW, 16, RAM word-address width
DW, 32, data width
CW, 16, word-count width
DEPTH, 4, FIFO entries; power of 2, >= 2

Ports:
hclk  in  1  clock
hrst  in  1  reset; synchronous, active-high
start  in  1  one-cycle pulse; loads start_addr/word_cnt, aborts any transfer in progress
start_addr  in  AW  first RAM word address, sampled on start
word_cnt  in  CW  number of words to send, sampled on start; 0 is legal
ram_rd_req  out  1  read request, held until ack
ram_rd_addr  out  AW  read address, stable while req is high
ram_rd_ack  in  1  read accept; ram_rdata is valid in the same cycle
ram_rdata  in  DW  read data
tx_vld  out  1  FIFO head valid
tx_rdy  in  1  PSRAM TX engine accepts the head
tx_data  out  DW  FIFO head data, show-ahead
busy  out  1  transfer active
done  out  1  one-cycle pulse when the transfer is complete

Behaviour:
- Reset (hrst=1 at a hclk edge): state IDLE; ram_rd_req=0; ram_rd_addr=0; tx_vld=0; tx_data=0; busy=0; done=0; FIFO empty; all counters 0.
- States:
  - IDLE
    - On start with word_cnt>0: go to FETCH.
    - On start with word_cnt=0: done=1 in the following cycle, then stay in IDLE.
  - FETCH
    - Issue requests while fetch_left>0.
    - When fetch_left reaches 0: go to DRAIN.
  - DRAIN
    - Wait until send_left=0.
    - Then done=1 for one cycle and return to IDLE.
- busy=1 in FETCH and DRAIN.
- Counters:
  - fetch_left = words not yet acked.
  - send_left = words not yet popped.
  - Both load word_cnt on start.
- Request rule:
  - At most one request outstanding.
  - ram_rd_req is registered.
  - Next-cycle req=1 iff state is FETCH and fetch_left_next>0 and fifo_count_next<DEPTH.
  - Back-to-back reads are therefore possible: req stays high across an ack, and ram_rd_addr advances to addr+1 in the next cycle.
- Ack handling:
  - ram_rd_ack && ram_rd_req: push ram_rdata into the FIFO, ram_rd_addr+=1 (wraps modulo 2^AW), fetch_left-=1.
  - ram_rd_ack while req=0: ignored.
- Latency:
  - start at cycle 0: req=1 at cycle 1 with addr=start_addr.
  - ack at cycle k: tx_vld=1 at cycle k+1.
- Pop: tx_vld && tx_rdy pops the head and decrements send_left. tx_data is stable while tx_vld=1 and tx_rdy=0.
- FIFO full/empty:
  - Full: req is withheld. It cannot overflow, because only one read is outstanding and req requires count<DEPTH.
  - Empty: tx_vld=0.
  - Push and pop in the same cycle: count is unchanged.
- done asserts in the cycle after the final pop, exactly once per transfer.
- start while busy (abort):
  - Flush the FIFO and reload address and counters.
  - No done is generated for the aborted transfer.
  - An ack in the same cycle as start is ignored.
  - ram_rd_req drops to 0 in the cycle after start, then restarts per the request rule. The RAM arbiter must tolerate req withdrawal.
- hrst mid-transfer: all state returns to reset values in the next cycle, with no done.

Decomposition:
- Shared package psram_pkg holds:
  - state enum {IDLE, FETCH, DRAIN};
  - default localparams for AW, DW, CW.
- Sub-module psram_tx_fifo:
  - synchronous show-ahead FIFO (DW, DEPTH);
  - ports push, pop, flush, din, dout, count, empty, full;
  - same clock and reset as the parent.

Test Plan:
- Basic transfer:
  - Stimulus: start, start_addr=0x0010, word_cnt=3; ack in the same cycle as each req; tx_rdy=1.
  - Response: addrs 0x10, 0x11, 0x12 requested; tx_data sequence matches RAM; one done pulse; busy then drops.
- Backpressure:
  - Stimulus: word_cnt=8, DEPTH=4, tx_rdy=0.
  - Response: exactly 4 acks, then req stays 0. Raising tx_rdy delivers all 8 words in order, then done.
- Zero length:
  - Stimulus: start, word_cnt=0.
  - Response: no ram_rd_req; done=1 at cycle 1; busy remains 0.
- Abort:
  - Stimulus: start word_cnt=6 at addr 0x100; after 2 pops, start word_cnt=2 at addr 0x200.
  - Response: FIFO flushed; next req addr=0x200; exactly 2 words sent; a single done.
- Address wrap:
  - Stimulus: AW=16, start_addr=0xFFFF, word_cnt=2.
  - Response: requests to 0xFFFF then 0x0000.
- Random stall and reset:
  - Stimulus: random ack delay and tx_rdy over 1000 words; spurious acks while req=0; hrst mid-transfer.
  - Response: data order and count correct; spurious acks ignored; outputs at reset values in the cycle after hrst.
